// File: rtl/npc_pkg.sv
// npc_pkg: shared encodings for the NPC multi-cycle core.
// Holds the RV32I opcode / funct3 / funct7 constants for the supported
// subset, the EBREAK instruction word, and the core's state enum.
package npc_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // funct3 / funct7 values used by the subset
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  // The one SYSTEM encoding that is accepted
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    EXEC,
    HALT
  } state_t;

endpackage

// File: rtl/npc_regfile.sv
// npc_regfile: integer register file for the NPC core.
// Ports:
//   clk, reset            clock and synchronous active-high reset (clears all entries)
//   i_raddr1 / o_rdata1   asynchronous read port 1
//   i_raddr2 / o_rdata2   asynchronous read port 2
//   i_we, i_waddr, i_wdata synchronous write port
// x0 always reads as zero; writes to x0 or to indices beyond NR_REGS are dropped.
module npc_regfile #(
  parameter int NR_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_raddr1,
  output logic [31:0] o_rdata1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  localparam int AW = $clog2(NR_REGS);
  localparam logic [5:0] NR_LIMIT = 6'(NR_REGS);

  logic [31:0] r_regs [NR_REGS];

  // Entry 0 is never written, but the read mux still forces zero so x0
  // cannot be disturbed by anything that does reach the array.
  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1[AW-1:0]];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR_REGS; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (i_we && (i_waddr != 5'd0) && ({1'b0, i_waddr} < NR_LIMIT)) begin
      r_regs[i_waddr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/npc_mc_core.sv
// npc_mc_core: multi-cycle RV32I-subset core (ADDI, ADD, SUB, LUI, AUIPC,
// JAL, JALR, EBREAK) with a valid/ready instruction-fetch handshake.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr fetch request (addr == pc)
//   imem_rsp_valid/data             fetched instruction word
//   pc                              current program counter
//   commit_valid, commit_pc         one pulse per retired instruction
//   halt, illegal, halt_code        stop status; halt_code is x10 at halt entry
// Sequence per instruction: FETCH -> WAIT -> EXEC -> FETCH (or HALT).
module npc_mc_core
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NR_REGS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic        halt,
  output logic        illegal,
  output logic [31:0] halt_code
);

  localparam bit IS_RV32E = (NR_REGS == 16);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_halt;
  logic        r_illegal;
  logic [31:0] r_halt_code;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [4:0]  w_raddr2;

  logic        w_legal;
  logic        w_wen;
  logic [31:0] w_wdata;
  logic [31:0] w_next_pc;
  logic        w_is_jump;
  logic        w_is_ebreak;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_uses_rd;
  logic        w_reg_bad;
  logic        w_decode_fault;
  logic        w_misaligned;
  logic        w_fault;
  logic        w_stop;
  logic        w_in_exec;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_funct3 = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_funct7 = r_instr[31:25];
  assign w_imm_i  = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_u  = {r_instr[31:12], 12'd0};
  assign w_imm_j  = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                     r_instr[20], r_instr[30:21], 1'b0};

  // Decode and ALU. Everything defaults to "illegal, no write, pc+4" so
  // only the recognised encodings need to set anything.
  always_comb begin
    w_legal     = 1'b0;
    w_wen       = 1'b0;
    w_wdata     = 32'd0;
    w_next_pc   = r_pc + 32'd4;
    w_is_jump   = 1'b0;
    w_is_ebreak = 1'b0;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    w_uses_rd   = 1'b0;
    case (w_opcode)
      OP_IMM: begin
        if (w_funct3 == F3_ADD_SUB) begin
          w_legal    = 1'b1;
          w_wen      = 1'b1;
          w_uses_rs1 = 1'b1;
          w_uses_rd  = 1'b1;
          w_wdata    = w_rs1_data + w_imm_i;
        end
      end
      OP_REG: begin
        if (w_funct3 == F3_ADD_SUB && (w_funct7 == F7_ADD || w_funct7 == F7_SUB)) begin
          w_legal    = 1'b1;
          w_wen      = 1'b1;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
          w_uses_rd  = 1'b1;
          w_wdata    = (w_funct7 == F7_SUB) ? (w_rs1_data - w_rs2_data)
                                            : (w_rs1_data + w_rs2_data);
        end
      end
      OP_LUI: begin
        w_legal   = 1'b1;
        w_wen     = 1'b1;
        w_uses_rd = 1'b1;
        w_wdata   = w_imm_u;
      end
      OP_AUIPC: begin
        w_legal   = 1'b1;
        w_wen     = 1'b1;
        w_uses_rd = 1'b1;
        w_wdata   = r_pc + w_imm_u;
      end
      OP_JAL: begin
        w_legal   = 1'b1;
        w_wen     = 1'b1;
        w_uses_rd = 1'b1;
        w_is_jump = 1'b1;
        w_wdata   = r_pc + 32'd4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        if (w_funct3 == F3_JALR) begin
          w_legal    = 1'b1;
          w_wen      = 1'b1;
          w_uses_rs1 = 1'b1;
          w_uses_rd  = 1'b1;
          w_is_jump  = 1'b1;
          w_wdata    = r_pc + 32'd4;
          w_next_pc  = (w_rs1_data + w_imm_i) & 32'hFFFF_FFFE;
        end
      end
      OP_SYSTEM: begin
        if (r_instr == EBREAK_WORD) begin
          w_legal     = 1'b1;
          w_is_ebreak = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // RV32E only rejects register fields the instruction actually uses;
  // immediate bits that happen to sit in those positions are not checked.
  assign w_reg_bad = IS_RV32E && ((w_uses_rs1 && w_rs1[4]) ||
                                  (w_uses_rs2 && w_rs2[4]) ||
                                  (w_uses_rd  && w_rd[4]));

  assign w_decode_fault = !w_legal || w_reg_bad;
  assign w_misaligned   = w_is_jump && w_next_pc[1];
  assign w_fault        = w_decode_fault || w_misaligned;
  assign w_stop         = w_fault || w_is_ebreak;
  assign w_in_exec      = (r_state == EXEC) && !reset;

  // Read port 2 is borrowed to read x10 whenever the instruction does not
  // need rs2. Every halting case (EBREAK, decode fault, misaligned jump)
  // lands here, so halt_code never needs a third read port.
  assign w_raddr2 = (w_uses_rs2 && !w_decode_fault) ? w_rs2 : 5'd10;

  npc_regfile #(
    .NR_REGS(NR_REGS)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .i_raddr1 (w_rs1),
    .o_rdata1 (w_rs1_data),
    .i_raddr2 (w_raddr2),
    .o_rdata2 (w_rs2_data),
    .i_we     (w_in_exec && !w_fault && w_wen),
    .i_waddr  (w_rd),
    .i_wdata  (w_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Responses are only looked at in WAIT, so a stray
  // imem_rsp_valid in FETCH or HALT has no effect.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: if (imem_req_ready) w_state_next = WAIT;
      WAIT:  if (imem_rsp_valid) w_state_next = EXEC;
      EXEC:  w_state_next = w_stop ? HALT : FETCH;
      HALT:  w_state_next = HALT;
      default: w_state_next = FETCH;
    endcase
  end

  // PC, latched instruction and halt status. A faulting instruction leaves
  // pc untouched; EBREAK also keeps pc pointing at itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_instr     <= 32'd0;
      r_halt      <= 1'b0;
      r_illegal   <= 1'b0;
      r_halt_code <= 32'd0;
    end else begin
      if (r_state == WAIT && imem_rsp_valid) begin
        r_instr <= imem_rsp_data;
      end
      if (r_state == EXEC) begin
        if (!w_stop) begin
          r_pc <= w_next_pc;
        end else begin
          r_halt      <= 1'b1;
          r_illegal   <= w_fault;
          r_halt_code <= w_rs2_data;
        end
      end
    end
  end

  assign imem_req_valid = (r_state == FETCH) && !reset;
  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign commit_valid   = w_in_exec && !w_fault;
  assign commit_pc      = r_pc;
  assign halt           = r_halt;
  assign illegal        = r_illegal;
  assign halt_code      = r_halt_code;

endmodule

// File: tb/tb_npc_mc_core.sv
// tb_npc_mc_core: directed self-checking bench for npc_mc_core.
// Two cores run in lockstep from the same fetch stimulus: dut (RV32I,
// 32 registers) and dut_e (RV32E, 16 registers). They only diverge when
// an instruction touches x16..x31.
module tb_npc_mc_core;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  logic        req_valid, commit_valid, halt, illegal;
  logic [31:0] addr, pc, commit_pc, halt_code;
  logic        e_req_valid, e_commit_valid, e_halt, e_illegal;
  logic [31:0] e_addr, e_pc, e_commit_pc, e_halt_code;

  int checks;
  int failures;

  npc_mc_core #(.RESET_PC(RPC), .NR_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .pc(pc), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .halt(halt), .illegal(illegal), .halt_code(halt_code)
  );

  npc_mc_core #(.RESET_PC(RPC), .NR_REGS(16)) dut_e (
    .clk(clk), .reset(reset),
    .imem_req_valid(e_req_valid), .imem_req_ready(ready), .imem_addr(e_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .pc(e_pc), .commit_valid(e_commit_valid), .commit_pc(e_commit_pc),
    .halt(e_halt), .illegal(e_illegal), .halt_code(e_halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two edges and releases it just after an edge.
  task automatic do_reset();
    reset     = 1'b1;
    ready     = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  // Runs one instruction with zero-wait memory. Returns the fetch address,
  // what both cores showed in their EXEC cycle, and leaves time at #1 after
  // the edge that ends EXEC.
  task automatic do_instr(input logic [31:0] instr, output logic [31:0] faddr,
                          output logic committed, output logic [31:0] cpc,
                          output logic e_committed);
    int n;
    n = 0;
    while (req_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_valid !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL fetch_timeout: req_valid=%b expected 1", req_valid);
    end
    faddr = addr;
    ready = 1'b1;
    @(posedge clk); #1;
    ready     = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = instr;
    @(posedge clk); #1;
    rsp_valid   = 1'b0;
    committed   = commit_valid;
    cpc         = commit_pc;
    e_committed = e_commit_valid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== RPC) begin failures++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, RPC); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid: got %b expected 0", req_valid); end
    checks++; if ({commit_valid, halt, illegal} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags: got %b expected 000", {commit_valid, halt, illegal}); end
    checks++; if (halt_code !== 32'd0) begin failures++; $display("[TB] FAIL reset_halt_code: got %h expected 0", halt_code); end
    checks++; if (dut.u_rf.r_regs[10] !== 32'd0) begin failures++; $display("[TB] FAIL reset_x10: got %h expected 0", dut.u_rf.r_regs[10]); end
    reset = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1 || addr !== RPC) begin failures++; $display("[TB] FAIL first_req: got valid=%b addr=%h expected 1 %h", req_valid, addr, RPC); end
  endtask

  task automatic test_addi();
    logic [31:0] fa, cp;
    logic cv, ecv;
    do_reset();
    do_instr(32'h0050_0093, fa, cv, cp, ecv);
    checks++; if (fa !== RPC) begin failures++; $display("[TB] FAIL addi_fetch_addr: got %h expected %h", fa, RPC); end
    checks++; if (cv !== 1'b1 || cp !== RPC) begin failures++; $display("[TB] FAIL addi_commit: got %b %h expected 1 %h", cv, cp, RPC); end
    checks++; if (dut.u_rf.r_regs[1] !== 32'd5) begin failures++; $display("[TB] FAIL addi_x1: got %h expected 5", dut.u_rf.r_regs[1]); end
    checks++; if (req_valid !== 1'b1 || addr !== 32'h8000_0004) begin failures++; $display("[TB] FAIL addi_next_addr: got %b %h expected 1 80000004", req_valid, addr); end
  endtask

  task automatic test_arith();
    logic [31:0] fa, cp;
    logic cv, ecv;
    do_reset();
    do_instr(32'hFFF0_0093, fa, cv, cp, ecv);  // addi x1,x0,-1
    do_instr(32'h0010_8133, fa, cv, cp, ecv);  // add  x2,x1,x1
    do_instr(32'h4010_01B3, fa, cv, cp, ecv);  // sub  x3,x0,x1
    do_instr(32'h0070_0013, fa, cv, cp, ecv);  // addi x0,x0,7
    do_instr(32'h4000_8233, fa, cv, cp, ecv);  // sub  x4,x1,x0
    checks++; if (dut.u_rf.r_regs[1] !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL arith_x1: got %h expected ffffffff", dut.u_rf.r_regs[1]); end
    checks++; if (dut.u_rf.r_regs[2] !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL arith_x2_wrap: got %h expected fffffffe", dut.u_rf.r_regs[2]); end
    checks++; if (dut.u_rf.r_regs[3] !== 32'd1) begin failures++; $display("[TB] FAIL arith_x3: got %h expected 1", dut.u_rf.r_regs[3]); end
    checks++; if (dut.u_rf.r_regs[4] !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL x0_reads_zero: got x4=%h expected ffffffff", dut.u_rf.r_regs[4]); end
    checks++; if (cp !== 32'h8000_0010) begin failures++; $display("[TB] FAIL arith_commit_pc: got %h expected 80000010", cp); end
  endtask

  task automatic test_upper_jump();
    logic [31:0] fa, cp;
    logic cv, ecv;
    do_reset();
    do_instr(32'h1234_52B7, fa, cv, cp, ecv);  // lui   x5,0x12345
    do_instr(32'h0000_1317, fa, cv, cp, ecv);  // auipc x6,1
    checks++; if (dut.u_rf.r_regs[5] !== 32'h1234_5000) begin failures++; $display("[TB] FAIL lui_x5: got %h expected 12345000", dut.u_rf.r_regs[5]); end
    checks++; if (dut.u_rf.r_regs[6] !== 32'h8000_1004) begin failures++; $display("[TB] FAIL auipc_x6: got %h expected 80001004", dut.u_rf.r_regs[6]); end
    do_instr(32'h0080_00EF, fa, cv, cp, ecv);  // jal x1,+8 at 0x80000008
    checks++; if (fa !== 32'h8000_0008 || dut.u_rf.r_regs[1] !== 32'h8000_000C) begin failures++; $display("[TB] FAIL jal_link: got fa=%h x1=%h expected 80000008 8000000c", fa, dut.u_rf.r_regs[1]); end
    checks++; if (addr !== 32'h8000_0010) begin failures++; $display("[TB] FAIL jal_target: got %h expected 80000010", addr); end
    do_instr(32'h8000_02B7, fa, cv, cp, ecv);  // lui  x5,0x80000
    do_instr(32'h1012_8293, fa, cv, cp, ecv);  // addi x5,x5,0x101
    do_instr(32'h0002_8067, fa, cv, cp, ecv);  // jalr x0,0(x5)
    checks++; if (cv !== 1'b1 || cp !== 32'h8000_0018) begin failures++; $display("[TB] FAIL jalr_commit: got %b %h expected 1 80000018", cv, cp); end
    checks++; if (addr !== 32'h8000_0100) begin failures++; $display("[TB] FAIL jalr_target: got %h expected 80000100", addr); end
  endtask

  task automatic test_misaligned();
    logic [31:0] fa, cp;
    logic cv, ecv;
    do_reset();
    do_instr(32'h0060_00EF, fa, cv, cp, ecv);  // jal x1,+6 -> bit 1 set
    checks++; if (cv !== 1'b0) begin failures++; $display("[TB] FAIL misaligned_commit: got %b expected 0", cv); end
    checks++; if ({halt, illegal} !== 2'b11) begin failures++; $display("[TB] FAIL misaligned_halt: got %b expected 11", {halt, illegal}); end
    checks++; if (pc !== RPC || dut.u_rf.r_regs[1] !== 32'd0) begin failures++; $display("[TB] FAIL misaligned_state: got pc=%h x1=%h expected %h 0", pc, dut.u_rf.r_regs[1], RPC); end
  endtask

  task automatic test_ebreak();
    logic [31:0] fa, cp;
    logic cv, ecv;
    int reqs, commits;
    do_reset();
    do_instr(32'h02A0_0513, fa, cv, cp, ecv);  // addi x10,x0,42
    do_instr(32'h0010_0073, fa, cv, cp, ecv);  // ebreak
    checks++; if (cv !== 1'b1 || cp !== 32'h8000_0004) begin failures++; $display("[TB] FAIL ebreak_commit: got %b %h expected 1 80000004", cv, cp); end
    checks++; if ({halt, illegal} !== 2'b10) begin failures++; $display("[TB] FAIL ebreak_halt: got %b expected 10", {halt, illegal}); end
    checks++; if (halt_code !== 32'd42) begin failures++; $display("[TB] FAIL ebreak_halt_code: got %h expected 2a", halt_code); end
    reqs = 0; commits = 0;
    ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    for (int i = 0; i < 5; i++) begin
      if (req_valid === 1'b1) reqs++;
      if (commit_valid === 1'b1) commits++;
      @(posedge clk); #1;
    end
    ready = 1'b0; rsp_valid = 1'b0;
    checks++; if (reqs != 0 || commits != 0) begin failures++; $display("[TB] FAIL halt_quiet: got reqs=%0d commits=%0d expected 0 0", reqs, commits); end
    checks++; if (halt !== 1'b1) begin failures++; $display("[TB] FAIL halt_held: got %b expected 1", halt); end
    do_reset();
    checks++; if (halt !== 1'b0 || req_valid !== 1'b1) begin failures++; $display("[TB] FAIL halt_reset: got halt=%b req=%b expected 0 1", halt, req_valid); end
  endtask

  task automatic test_stall();
    int bad, commits;
    do_reset();
    bad = 0; commits = 0;
    rsp_data = 32'h0050_0093;
    for (int i = 0; i < 10; i++) begin
      ready     = 1'b0;
      rsp_valid = (i < 3);
      @(posedge clk); #1;
      if (req_valid !== 1'b1 || addr !== RPC) bad++;
      if (commit_valid === 1'b1) commits++;
    end
    rsp_valid = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL stall_fetch_stable: got %0d bad cycles expected 0", bad); end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (req_valid !== 1'b0 || addr !== RPC) bad++;
      if (commit_valid === 1'b1) commits++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL stall_wait_stable: got %0d bad cycles expected 0", bad); end
    rsp_valid = 1'b1; rsp_data = 32'h0090_0093;  // addi x1,x0,9
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (commit_valid === 1'b1) commits++;
      @(posedge clk); #1;
    end
    checks++; if (commits != 1) begin failures++; $display("[TB] FAIL stall_commit_count: got %0d expected 1", commits); end
    checks++; if (dut.u_rf.r_regs[1] !== 32'd9) begin failures++; $display("[TB] FAIL stall_x1: got %h expected 9", dut.u_rf.r_regs[1]); end
  endtask

  task automatic test_rv32e();
    logic [31:0] fa, cp;
    logic cv, ecv;
    do_reset();
    do_instr(32'h0010_0813, fa, cv, cp, ecv);  // addi x16,x0,1
    checks++; if (cv !== 1'b1 || dut.u_rf.r_regs[16] !== 32'd1) begin failures++; $display("[TB] FAIL rv32i_x16: got %b %h expected 1 1", cv, dut.u_rf.r_regs[16]); end
    checks++; if (ecv !== 1'b0) begin failures++; $display("[TB] FAIL rv32e_x16_commit: got %b expected 0", ecv); end
    checks++; if ({e_halt, e_illegal} !== 2'b11) begin failures++; $display("[TB] FAIL rv32e_x16_halt: got %b expected 11", {e_halt, e_illegal}); end
    do_reset();
    do_instr(32'hFFFF_FFFF, fa, cv, cp, ecv);
    checks++; if (cv !== 1'b0 || ecv !== 1'b0) begin failures++; $display("[TB] FAIL bad_opcode_commit: got %b %b expected 0 0", cv, ecv); end
    checks++; if ({halt, illegal, e_halt, e_illegal} !== 4'b1111) begin failures++; $display("[TB] FAIL bad_opcode_halt: got %b expected 1111", {halt, illegal, e_halt, e_illegal}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] fa, cp;
    logic cv, ecv;
    int bad;
    do_reset();
    do_instr(32'h0050_0093, fa, cv, cp, ecv);  // addi x1,x0,5
    ready = 1'b1;
    @(posedge clk); #1;                          // now in WAIT
    ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (pc !== RPC || dut.u_rf.r_regs[1] !== 32'd0) begin failures++; $display("[TB] FAIL midreset_state: got pc=%h x1=%h expected %h 0", pc, dut.u_rf.r_regs[1], RPC); end
    reset = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (req_valid !== 1'b1 || addr !== RPC || commit_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    rsp_valid = 1'b0;
    checks++; if (bad != 0 || dut.u_rf.r_regs[1] !== 32'd0) begin failures++; $display("[TB] FAIL stale_rsp: got bad=%0d x1=%h expected 0 0", bad, dut.u_rf.r_regs[1]); end
    do_instr(32'h0030_0113, fa, cv, cp, ecv);  // addi x2,x0,3
    checks++; if (cv !== 1'b1 || cp !== RPC || dut.u_rf.r_regs[2] !== 32'd3) begin failures++; $display("[TB] FAIL restart: got %b %h x2=%h expected 1 %h 3", cv, cp, dut.u_rf.r_regs[2], RPC); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0;
    test_reset();
    test_addi();
    test_arith();
    test_upper_jump();
    test_misaligned();
    test_ebreak();
    test_stall();
    test_rv32e();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
